// File: rtl/alu4_result_checker.sv
// Golden-model response checker for alu4: 2-stage pipeline, mismatch 2 cycles after accept.
// Always ready (full throughput in RUN); in_valid outside RUN is dropped.
module alu4_result_checker #(
  parameter int NUM_VECTORS = 1280,
  parameter int CNT_W       = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  input  logic [3:0]       a,
  input  logic [3:0]       b,
  input  logic             add_sub,
  input  logic [1:0]       op,
  input  logic [3:0]       dut_f,
  input  logic             dut_zero,
  input  logic             dut_overflow,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             mismatch,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [14:0]      first_err
);
  // Run length is tracked separately so a narrow CNT_W only saturates the reported count.
  localparam int RUN_W = $clog2(NUM_VECTORS + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t           r_state;
  logic [RUN_W-1:0] r_run_cnt;
  logic             r_drain;
  logic             r_s1_vld, r_s1_chk;
  logic [3:0]       r_s1_exp_f, r_s1_dut_f;
  logic             r_s1_exp_z, r_s1_exp_o, r_s1_dut_z, r_s1_dut_o;
  logic [10:0]      r_s1_ops;
  logic             r_s2_vld, r_s2_miss;
  logic [14:0]      r_s2_tag;

  logic       w_acc, w_last, w_chk, w_exp_z, w_exp_o;
  logic [3:0] w_exp_f, w_sum, w_dif;

  assign w_sum = a + b;
  assign w_dif = a - b;

  always_comb begin
    w_exp_f = 4'h0;
    w_exp_o = 1'b0;
    w_chk   = 1'b1;
    case ({add_sub, op})
      3'b000: w_exp_f = a & b;
      3'b001: w_exp_f = a | b;
      3'b010: begin
        w_exp_f = w_sum;
        w_exp_o = (a[3] == b[3]) && (w_sum[3] != a[3]);
      end
      3'b110: begin
        w_exp_f = w_dif;
        w_exp_o = (a[3] != b[3]) && (w_dif[3] != a[3]);
      end
      3'b111: w_exp_f = {3'b000, ($signed(a) < $signed(b))};
      default: w_chk = 1'b0;
    endcase
    w_exp_z = (w_exp_f == 4'h0);
  end

  assign w_acc  = (r_state == S_RUN) && in_valid && !start;
  assign w_last = (r_run_cnt == RUN_W'(NUM_VECTORS - 1));
  assign pass   = done && (err_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_chk   <= 1'b0;
      r_s1_exp_f <= 4'h0;
      r_s1_exp_z <= 1'b0;
      r_s1_exp_o <= 1'b0;
      r_s1_dut_f <= 4'h0;
      r_s1_dut_z <= 1'b0;
      r_s1_dut_o <= 1'b0;
      r_s1_ops   <= 11'h0;
      r_s2_miss  <= 1'b0;
      r_s2_tag   <= 15'h0;
    end else begin
      r_s1_chk   <= w_chk;
      r_s1_exp_f <= w_exp_f;
      r_s1_exp_z <= w_exp_z;
      r_s1_exp_o <= w_exp_o;
      r_s1_dut_f <= dut_f;
      r_s1_dut_z <= dut_zero;
      r_s1_dut_o <= dut_overflow;
      r_s1_ops   <= {add_sub, op, a, b};
      r_s2_miss  <= r_s1_chk &&
                    ({r_s1_dut_f, r_s1_dut_z, r_s1_dut_o} != {r_s1_exp_f, r_s1_exp_z, r_s1_exp_o});
      r_s2_tag   <= {r_s1_ops, r_s1_dut_f};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_run_cnt <= '0;
      r_drain   <= 1'b0;
      r_s1_vld  <= 1'b0;
      r_s2_vld  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mismatch  <= 1'b0;
      vec_cnt   <= '0;
      err_cnt   <= '0;
      first_err <= 15'h0;
    end else if (start) begin
      // Restart from any state: in-flight compares are discarded with the old run.
      r_state   <= S_RUN;
      r_run_cnt <= '0;
      r_drain   <= 1'b0;
      r_s1_vld  <= 1'b0;
      r_s2_vld  <= 1'b0;
      busy      <= 1'b1;
      done      <= 1'b0;
      mismatch  <= 1'b0;
      vec_cnt   <= '0;
      err_cnt   <= '0;
      first_err <= 15'h0;
    end else begin
      r_s1_vld <= w_acc;
      r_s2_vld <= r_s1_vld;
      mismatch <= r_s2_vld && r_s2_miss;
      if (r_s2_vld && r_s2_miss) begin
        if (err_cnt == '0) first_err <= r_s2_tag;
        if (err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
      end
      if (w_acc) begin
        r_run_cnt <= r_run_cnt + RUN_W'(1);
        if (vec_cnt != '1) vec_cnt <= vec_cnt + CNT_W'(1);
      end
      case (r_state)
        S_RUN: if (w_acc && w_last) begin
          r_state <= S_DRAIN;
          r_drain <= 1'b0;
        end
        S_DRAIN: begin
          if (r_drain) begin
            r_state <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            r_drain <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_alu4_result_checker.sv
// Randomised scoreboard bench for alu4_result_checker; a second narrow instance covers saturation.
module tb_alu4_result_checker;
  localparam int NUM = 1280;

  logic clk = 1'b0;
  logic rst_n, start, in_valid, add_sub, dut_zero, dut_overflow;
  logic [1:0] op;
  logic [3:0] a, b, dut_f;
  logic busy, done, pass, mismatch;
  logic [10:0] vec_cnt, err_cnt;
  logic [14:0] first_err;

  logic s_start, s_vld, s_z, s_o;
  logic [3:0] s_f;
  logic s_busy, s_done, s_pass, s_mm;
  logic [3:0] s_vec, s_err;
  logic [14:0] s_first;

  always #5 clk = ~clk;

  alu4_result_checker #(.NUM_VECTORS(NUM), .CNT_W(11)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .a(a), .b(b),
    .add_sub(add_sub), .op(op), .dut_f(dut_f), .dut_zero(dut_zero),
    .dut_overflow(dut_overflow), .busy(busy), .done(done), .pass(pass),
    .mismatch(mismatch), .vec_cnt(vec_cnt), .err_cnt(err_cnt), .first_err(first_err)
  );

  alu4_result_checker #(.NUM_VECTORS(20), .CNT_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(s_start), .in_valid(s_vld), .a(a), .b(b),
    .add_sub(add_sub), .op(op), .dut_f(s_f), .dut_zero(s_z),
    .dut_overflow(s_o), .busy(s_busy), .done(s_done), .pass(s_pass),
    .mismatch(s_mm), .vec_cnt(s_vec), .err_cnt(s_err), .first_err(s_first)
  );

  typedef struct {
    int          due;
    logic        miss;
    int          err;
    logic [14:0] first;
  } exp_t;

  exp_t        q[$];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          m_vec = 0;
  int          m_err = 0;
  logic [14:0] m_first = '0;
  bit          m_run = 1'b0;
  int          s_pulses = 0;
  logic [2:0]  codes [5];

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (s_mm) s_pulses++;

  task automatic chk(input string nm, input longint act, input longint expv);
    n_cmp++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Reference ALU in plain signed integer arithmetic.
  function automatic void ref_alu(input logic [2:0] code, input logic [3:0] ia, input logic [3:0] ib,
                                  output logic [3:0] f, output logic z, output logic o,
                                  output logic c);
    int sa, sb, r;
    sa = int'($signed(ia));
    sb = int'($signed(ib));
    r  = 0;
    o  = 1'b0;
    c  = 1'b1;
    case (code)
      3'b000: r = int'(ia & ib);
      3'b001: r = int'(ia | ib);
      3'b010: begin r = sa + sb; o = (r > 7) || (r < -8); end
      3'b110: begin r = sa - sb; o = (r > 7) || (r < -8); end
      3'b111: r = (sa < sb) ? 1 : 0;
      default: c = 1'b0;
    endcase
    f = 4'(r);
    z = (f == 4'h0);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply one cycle of stimulus; mask flips result bits {ovf,zero,f[3:0]} of a correct ALU.
  task automatic drive(input logic v, input logic st, input logic [2:0] code, input logic [3:0] ia,
                       input logic [3:0] ib, input logic [5:0] mask);
    logic [3:0] f;
    logic z, o, c;
    exp_t e;
    ref_alu(code, ia, ib, f, z, o, c);
    start        = st;
    in_valid     = v;
    {add_sub, op} = code;
    a            = ia;
    b            = ib;
    dut_f        = f ^ mask[3:0];
    dut_zero     = z ^ mask[4];
    dut_overflow = o ^ mask[5];
    if (st) begin
      while (q.size() > 0 && q[$].due > cyc) void'(q.pop_back());
      m_vec   = 0;
      m_err   = 0;
      m_first = '0;
      m_run   = 1'b1;
    end else if (v && m_run) begin
      m_vec++;
      e.miss = c && (mask != 6'h0);
      if (e.miss) begin
        if (m_err == 0) m_first = {code, ia, ib, dut_f};
        if (m_err < 2047) m_err++;
      end
      e.due   = cyc + 3;
      e.err   = m_err;
      e.first = m_first;
      q.push_back(e);
      if (m_vec == NUM) m_run = 1'b0;
    end
    tick();
  endtask

  task automatic drive_rand(input int err_rate);
    logic [5:0] mask;
    mask = ($urandom_range(err_rate - 1) == 0) ? 6'($urandom_range(63, 1)) : 6'h0;
    drive(1'b1, 1'b0, 3'($urandom), 4'($urandom), 4'($urandom), mask);
  endtask

  // Monitor: every accepted sample owes a mismatch verdict exactly at its due cycle.
  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].due < cyc) begin
      e = q.pop_front();
      chk("stale_expectation_due", e.due, cyc);
    end
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      chk("mismatch", mismatch, e.miss);
      chk("err_cnt", err_cnt, e.err);
      chk("first_err", first_err, e.first);
    end else begin
      chk("mismatch_idle", mismatch, 0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  f;
    logic        z, o, c;
    logic [2:0]  code;
    logic [14:0] s_tag;
    int          k;
    codes[0] = 3'b000; codes[1] = 3'b001; codes[2] = 3'b010; codes[3] = 3'b110; codes[4] = 3'b111;
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; add_sub = 1'b0; op = 2'b00;
    a = 4'h0; b = 4'h0; dut_f = 4'h0; dut_zero = 1'b0; dut_overflow = 1'b0;
    s_start = 1'b0; s_vld = 1'b0; s_f = 4'h0; s_z = 1'b0; s_o = 1'b0;
    s_tag = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_mismatch", mismatch, 0);
    chk("rst_vec_cnt", vec_cnt, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_first_err", first_err, 0);
    rst_n = 1'b1;
    tick();

    // Full clean run: every checked code x every operand pair, random idle gaps with junk data.
    drive(1'b0, 1'b1, 3'b000, 4'h0, 4'h0, 6'h0);
    chk("run_busy", busy, 1);
    for (int ci = 0; ci < 5; ci++) begin
      for (int ab = 0; ab < 256; ab++) begin
        if ($urandom_range(3) == 0)
          drive(1'b0, 1'b0, 3'($urandom), 4'($urandom), 4'($urandom), 6'($urandom));
        drive(1'b1, 1'b0, codes[ci], 4'(ab >> 4), 4'(ab), 6'h0);
      end
    end
    k = 0;
    while (!done && k < 10) begin drive(1'b0, 1'b0, 3'b000, 4'h0, 4'h0, 6'h0); k++; end
    chk("clean_done", done, 1);
    chk("clean_pass", pass, 1);
    chk("clean_busy", busy, 0);
    chk("clean_vec_cnt", vec_cnt, NUM);
    chk("clean_err_cnt", err_cnt, 0);
    drive(1'b1, 1'b0, 3'b010, 4'h7, 4'h1, 6'h3F);
    drive(1'b1, 1'b0, 3'b010, 4'h7, 4'h1, 6'h3F);
    chk("done_ignores_valid", vec_cnt, NUM);

    // Directed failures, then random traffic with injected errors.
    drive(1'b0, 1'b1, 3'b000, 4'h0, 4'h0, 6'h0);
    chk("restart_vec_cnt", vec_cnt, 0);
    chk("restart_done", done, 0);
    drive(1'b1, 1'b0, 3'b010, 4'h7, 4'h1, 6'h00);
    drive(1'b1, 1'b0, 3'b010, 4'h7, 4'h1, 6'h20);
    drive(1'b1, 1'b0, 3'b111, 4'hF, 4'h1, 6'h01);
    drive(1'b1, 1'b0, 3'b111, 4'h1, 4'hF, 6'h00);
    drive(1'b1, 1'b0, 3'b011, 4'h5, 4'h9, 6'h3F);
    for (int i = 0; i < 93; i++) drive_rand(8);
    drive(1'b1, 1'b0, 3'b001, 4'h3, 4'h4, 6'h02);
    drive(1'b1, 1'b0, 3'b110, 4'h8, 4'h1, 6'h10);
    chk("mid_vec_cnt", vec_cnt, 100);
    // Restart with a sample in the same cycle: clear wins, the sample is dropped.
    drive(1'b1, 1'b1, 3'b000, 4'h1, 4'h2, 6'h01);
    chk("flush_vec_cnt", vec_cnt, 0);
    chk("flush_err_cnt", err_cnt, 0);
    chk("flush_first_err", first_err, 0);
    chk("flush_busy", busy, 1);

    for (int i = 0; i < NUM; i++) begin
      if ($urandom_range(9) == 0) drive(1'b0, 1'b0, 3'($urandom), 4'($urandom), 4'($urandom), 6'h0);
      drive_rand(16);
    end
    chk("drain_busy", busy, 1);
    chk("drain_done", done, 0);
    rst_n = 1'b0;
    #1;
    q.delete();
    m_run = 1'b0;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_vec_cnt", vec_cnt, 0);
    chk("arst_err_cnt", err_cnt, 0);
    chk("arst_first_err", first_err, 0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 3'b010, 4'h7, 4'h1, 6'h3F);
    chk("idle_after_rst_busy", busy, 0);
    chk("idle_after_rst_vec", vec_cnt, 0);
    drive(1'b0, 1'b0, 3'b000, 4'h0, 4'h0, 6'h0);

    // Narrow instance: every sample wrong, counters saturate at all-ones.
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    chk("sat_busy", s_busy, 1);
    s_pulses = 0;
    for (int i = 0; i < 20; i++) begin
      code = codes[$urandom_range(4)];
      {add_sub, op} = code;
      a = 4'($urandom);
      b = 4'($urandom);
      ref_alu(code, a, b, f, z, o, c);
      s_f = f ^ 4'hF;
      s_z = z;
      s_o = o;
      s_vld = 1'b1;
      if (i == 0) s_tag = {code, a, b, s_f};
      tick();
    end
    s_vld = 1'b0;
    k = 0;
    while (!s_done && k < 10) begin tick(); k++; end
    tick();
    chk("sat_done", s_done, 1);
    chk("sat_pass", s_pass, 0);
    chk("sat_err_cnt", s_err, 15);
    chk("sat_vec_cnt", s_vec, 15);
    chk("sat_pulses", s_pulses, 20);
    chk("sat_first_err", s_first, s_tag);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
